// File: rtl/flp_generator.sv
// flp_generator: periodic IEEE 802.3 auto-negotiation Fast Link Pulse burst
// generator for the 10BASE-T transmit pair.
//
// A free-running burst counter wraps every BURST_PERIOD cycles. Alongside it,
// a slot/offset counter pair tracks cnt / SLOT and cnt % SLOT so that no
// divider is needed. Even slots 0..32 carry clock pulses. Odd slots 1..31
// carry LCW bits, LSB first. Everything after slot 32 is idle until the wrap.
// Txp and Txn are both registered, and Txn is held low permanently.
module flp_generator #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          PULSE_W      = 10,
    parameter int          SLOT         = 6250,
    parameter int          BURST_PERIOD = 1_600_000,
    parameter logic [15:0] LCW          = 16'h0021
) (
    input  logic clk,
    input  logic resetn,
    output logic Txp,
    output logic Txn
);

    localparam int CNT_W = (BURST_PERIOD > 1) ? $clog2(BURST_PERIOD) : 1;
    localparam int OFF_W = (SLOT > 1) ? $clog2(SLOT) : 1;

    // Slot 33 is the first idle slot. The slot counter saturates there so
    // that it fits in 6 bits whatever BURST_PERIOD is.
    localparam logic [5:0] LAST_SLOT = 6'd32;
    localparam logic [5:0] IDLE_SLOT = 6'd33;

    // Reject parameter sets that would produce overlapping or truncated bursts.
    if (CLK_HZ <= 0) begin : g_bad_clk
        $error("flp_generator: CLK_HZ must be positive");
    end
    if (PULSE_W < 1) begin : g_bad_pulse
        $error("flp_generator: PULSE_W must be at least 1");
    end
    if (SLOT <= PULSE_W) begin : g_bad_slot
        $error("flp_generator: SLOT must exceed PULSE_W");
    end
    if (BURST_PERIOD < 33 * SLOT) begin : g_bad_period
        $error("flp_generator: BURST_PERIOD must be at least 33*SLOT");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [5:0]       slot_q, slot_d;
    logic             txp_q, txp_d;
    logic             txn_q;

    logic             cnt_wrap;
    logic             off_wrap;
    logic             slot_en;

    // Counter next-state: the burst counter wraps, and the slot and offset
    // counters follow it.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_W'(BURST_PERIOD - 1));
        off_wrap = (off_q == OFF_W'(SLOT - 1));
        cnt_d    = cnt_q + CNT_W'(1);
        off_d    = off_q + OFF_W'(1);
        slot_d   = slot_q;
        if (cnt_wrap) begin
            cnt_d  = '0;
            off_d  = '0;
            slot_d = '0;
        end else if (off_wrap) begin
            off_d = '0;
            if (slot_q < IDLE_SLOT) begin
                slot_d = slot_q + 6'd1;
            end
        end
    end

    // Pulse condition for the current counter value. Clock slots are always
    // enabled. A data slot is enabled only when its LCW bit is 1.
    always_comb begin
        slot_en = 1'b1;
        if (slot_q[0]) begin
            slot_en = LCW[slot_q[4:1]];
        end
        txp_d = (slot_q <= LAST_SLOT) && (off_q < OFF_W'(PULSE_W)) && slot_en;
    end

    // Counter and line registers. Reset clears the line at once and restarts
    // the burst from slot 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            off_q  <= '0;
            slot_q <= '0;
            txp_q  <= 1'b0;
            txn_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            slot_q <= slot_d;
            txp_q  <= txp_d;
            txn_q  <= 1'b0;
        end
    end

    assign Txp = txp_q;
    assign Txn = txn_q;

endmodule

// File: tb/tb_flp_generator.sv
// Directed bench for flp_generator. It uses shrunk timing (PULSE_W=3,
// SLOT=10, BURST_PERIOD=400) so that whole bursts fit in a short run. Three
// instances share clock and reset and carry the LCW values 0021, FFFF and 0000.
// With these parameters, slot s starts on edge 10*s+1, the last clock pulse
// covers edges 321..323, the line is idle on edges 324..400, and the next
// burst starts on edge 401.
module tb_flp_generator;

    localparam int PW = 3;
    localparam int SL = 10;
    localparam int BP = 400;
    localparam int NE = 800;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic txp_d, txn_d, txp_o, txn_o, txp_z, txn_z;

    int tests = 0;
    int fails = 0;

    logic [NE:1] tp_d, tp_o, tp_z;
    int bad_line = 0;
    int lo_w, hi_w;

    flp_generator #(.CLK_HZ(100_000_000), .PULSE_W(PW), .SLOT(SL), .BURST_PERIOD(BP), .LCW(16'h0021))
        u_def (.clk(clk), .resetn(resetn), .Txp(txp_d), .Txn(txn_d));
    flp_generator #(.CLK_HZ(100_000_000), .PULSE_W(PW), .SLOT(SL), .BURST_PERIOD(BP), .LCW(16'hFFFF))
        u_ones (.clk(clk), .resetn(resetn), .Txp(txp_o), .Txn(txn_o));
    flp_generator #(.CLK_HZ(100_000_000), .PULSE_W(PW), .SLOT(SL), .BURST_PERIOD(BP), .LCW(16'h0000))
        u_zero (.clk(clk), .resetn(resetn), .Txp(txp_z), .Txn(txn_z));

    // Clock generation: 10 ns period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rises(input logic [NE:1] v, input int lo, input int hi);
        int n = 0;
        for (int e = lo; e <= hi; e++) begin
            if (v[e] && (e == 1 || !v[e-1])) n++;
        end
        return n;
    endfunction

    function automatic int highs(input logic [NE:1] v, input int lo, input int hi);
        int n = 0;
        for (int e = lo; e <= hi; e++) begin
            if (v[e]) n++;
        end
        return n;
    endfunction

    // Shortest and longest high run among the pulses that start in [lo, hi].
    task automatic widths(input logic [NE:1] v, input int lo, input int hi,
                          output int wmin, output int wmax);
        wmin = 1000;
        wmax = 0;
        for (int e = lo; e <= hi; e++) begin
            if (v[e] && (e == 1 || !v[e-1])) begin
                int w = 0;
                while (e + w <= NE && v[e+w]) w++;
                if (w < wmin) wmin = w;
                if (w > wmax) wmax = w;
            end
        end
    endtask

    // Edge number of the first pulse that starts after edge 'after', or 0 if none.
    function automatic int first_rise_after(input logic [NE:1] v, input int after);
        for (int e = after + 1; e <= NE; e++) begin
            if (v[e] && !v[e-1]) return e;
        end
        return 0;
    endfunction

    initial begin
        // Reset held for 7 cycles: the line stays idle throughout.
        resetn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("reset_idle", {txp_d, txn_d, txp_o, txn_o, txp_z, txn_z}, 0);
        end

        // Release between clock edges. The next rising edge is edge 1.
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= NE; e++) begin
            @(posedge clk);
            #1;
            tp_d[e] = txp_d;
            tp_o[e] = txp_o;
            tp_z[e] = txp_z;
            if (txn_d !== 1'b0 || txn_o !== 1'b0 || txn_z !== 1'b0) bad_line++;
            if ((txp_d & txn_d) || (txp_o & txn_o) || (txp_z & txn_z)) bad_line++;
        end

        // First pulse, and the directed positions in the default burst.
        check("def_edge1", tp_d[1], 1);
        check("def_edge3", tp_d[3], 1);
        check("def_edge4_fall", tp_d[4], 0);
        check("def_slot1_data", tp_d[11], 1);
        check("def_slot1_end", tp_d[14], 0);
        check("def_slot2_clock", tp_d[21], 1);
        check("def_slot3_bit1", tp_d[31], 0);
        check("def_slot11_bit5", tp_d[111], 1);
        check("def_slot13_bit6", tp_d[131], 0);
        check("def_slot32_start", tp_d[321], 1);
        check("def_slot32_last", tp_d[323], 1);
        check("def_slot32_fall", tp_d[324], 0);
        check("ones_slot3_bit1", tp_o[31], 1);
        check("zero_slot1_bit0", tp_z[11], 0);

        // Pulse counts per burst: 17 clock pulses plus the 1 bits of LCW.
        check("def_count_b1", rises(tp_d, 1, BP), 19);
        check("def_count_b2", rises(tp_d, BP + 1, NE), 19);
        check("ones_count_b1", rises(tp_o, 1, BP), 33);
        check("zero_count_b1", rises(tp_z, 1, BP), 17);

        // Every pulse is exactly PW cycles wide.
        widths(tp_d, 1, NE, lo_w, hi_w);
        check("def_width_min", lo_w, PW);
        check("def_width_max", hi_w, PW);
        widths(tp_o, 1, BP, lo_w, hi_w);
        check("ones_width_min", lo_w, PW);
        check("ones_width_max", hi_w, PW);

        // Spacing: uniform SL for all-ones, 2*SL for all-zeros.
        check("ones_spacing", first_rise_after(tp_o, 1) - 1, SL);
        check("ones_spacing_mid", first_rise_after(tp_o, 161) - 161, SL);
        check("zero_spacing", first_rise_after(tp_z, 1) - 1, 2 * SL);
        check("zero_spacing_mid", first_rise_after(tp_z, 161) - 161, 2 * SL);

        // Burst period and the idle gap after the burst.
        check("def_period", first_rise_after(tp_d, 1 + 32 * SL) - 1, BP);
        check("ones_period", first_rise_after(tp_o, 1 + 32 * SL) - 1, BP);
        check("def_idle_gap", highs(tp_d, 32 * SL + PW + 1, BP), 0);
        check("ones_idle_gap", highs(tp_o, 32 * SL + PW + 1, BP), 0);

        check("line_invariant", bad_line, 0);

        // Reset in the middle of the slot-1 pulse of the third burst (edge 812).
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_pulse", txp_d, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_def", txp_d, 0);
        check("async_reset_ones", txp_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {txp_d, txn_d, txp_o, txn_o}, 0);

        // After release, the burst restarts from slot 0.
        @(negedge clk);
        resetn = 1'b1;
        tp_d = '0;
        tp_z = '0;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            tp_d[e] = txp_d;
            tp_z[e] = txp_z;
        end
        check("restart_edge1", tp_d[1], 1);
        check("restart_edge3", tp_d[3], 1);
        check("restart_edge4", tp_d[4], 0);
        check("restart_slot1", tp_d[11], 1);
        check("restart_zero_slot1", tp_z[11], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
